// File: rtl/flux_pkg.sv
// rtl/flux_pkg.sv - shared constants, state types and byte merge helper for the flux write path
package flux_pkg;

  // Bit-cell lengths in CLK_14M cycles: 2 us (3.5") and 4 us (5.25")
  localparam int CELL_CLKS_35  = 28;
  localparam int CELL_CLKS_525 = 56;

  // Head bit position width (covers the longest WOZ track)
  localparam int POS_W = 17;

  // Write session: idle, committing cells, draining the last partial byte
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DRAIN = 2'd2
  } sess_state_t;

  // Read-modify-write flush sequence
  typedef enum logic [1:0] {
    F_IDLE = 2'd0,
    F_RD   = 2'd1,
    F_WAIT = 2'd2,
    F_WR   = 2'd3
  } flush_state_t;

  // Replace only the masked bits of an existing track byte
  function automatic logic [7:0] merge_byte(input logic [7:0] old_b,
                                            input logic [7:0] new_b,
                                            input logic [7:0] mask);
    return (old_b & ~mask) | (new_b & mask);
  endfunction

endpackage

// File: rtl/flux_byte_merge.sv
// rtl/flux_byte_merge.sv - three-cycle read-modify-write flush engine with a one-deep pending slot
module flux_byte_merge
  import flux_pkg::*;
#(
  parameter int AW = 14
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  input  logic [7:0]    i_data,
  input  logic [7:0]    i_mask,
  input  logic [7:0]    i_rdata,
  output logic [AW-1:0] o_addr,
  output logic [7:0]    o_wdata,
  output logic          o_we,
  output logic          o_busy
);

  flush_state_t  r_state;
  logic [AW-1:0] r_addr;
  logic [7:0]    r_data;
  logic [7:0]    r_mask;
  logic [7:0]    r_wdata;
  logic          r_we;
  logic          r_pend_vld;
  logic [AW-1:0] r_pend_addr;
  logic [7:0]    r_pend_data;
  logic [7:0]    r_pend_mask;

  // Flush sequencer: RD presents the address, WAIT covers BRAM latency and
  // computes the merge, WR holds the strobe for one cycle; then the pending
  // slot, if occupied, starts the next sequence back to back.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= F_IDLE;
      r_addr      <= '0;
      r_data      <= '0;
      r_mask      <= '0;
      r_wdata     <= '0;
      r_we        <= 1'b0;
      r_pend_vld  <= 1'b0;
      r_pend_addr <= '0;
      r_pend_data <= '0;
      r_pend_mask <= '0;
    end else begin
      r_we <= 1'b0;
      case (r_state)
        F_IDLE: begin
          if (i_req) begin
            r_addr  <= i_addr;
            r_data  <= i_data;
            r_mask  <= i_mask;
            r_state <= F_RD;
          end
        end
        F_RD: begin
          r_state <= F_WAIT;
        end
        F_WAIT: begin
          r_wdata <= merge_byte(i_rdata, r_data, r_mask);
          r_we    <= 1'b1;
          r_state <= F_WR;
        end
        F_WR: begin
          if (r_pend_vld) begin
            r_addr     <= r_pend_addr;
            r_data     <= r_pend_data;
            r_mask     <= r_pend_mask;
            r_pend_vld <= 1'b0;
            r_state    <= F_RD;
          end else begin
            r_state <= F_IDLE;
          end
        end
        default: r_state <= F_IDLE;
      endcase
      // A request that lands while a sequence is running parks here; a later
      // assignment overrides the slot release above when both happen in F_WR.
      if (i_req && (r_state != F_IDLE)) begin
        r_pend_vld  <= 1'b1;
        r_pend_addr <= i_addr;
        r_pend_data <= i_data;
        r_pend_mask <= i_mask;
      end
    end
  end

  assign o_addr  = r_addr;
  assign o_wdata = r_wdata;
  assign o_we    = r_we;
  assign o_busy  = (r_state != F_IDLE) | r_pend_vld;

endmodule

// File: rtl/flux_track_writer.sv
// rtl/flux_track_writer.sv - samples IWM write flux per bit cell and merges WOZ bits into the track BRAM (optional FLUX_WRITE_STATS_EN)
module flux_track_writer
  import flux_pkg::*;
#(
  parameter int CLKS_PER_BIT_35  = CELL_CLKS_35,
  parameter int CLKS_PER_BIT_525 = CELL_CLKS_525,
  parameter int BRAM_AW          = 14
) (
  input  logic               CLK_14M,
  input  logic               RESET,
  input  logic               IS_35_INCH,
  input  logic               WRITE_ACTIVE,
  input  logic               FLUX_WRITE,
  input  logic               MOTOR_SPINNING,
  input  logic               TRACK_LOADED,
  input  logic               WRITE_PROTECT,
  input  logic [POS_W-1:0]   BIT_POSITION,
  input  logic [31:0]        TRACK_BIT_COUNT,
  output logic [BRAM_AW-1:0] BRAM_ADDR,
  input  logic [7:0]         BRAM_RDATA,
  output logic [7:0]         BRAM_WDATA,
  output logic               BRAM_WE,
  output logic [POS_W-1:0]   WR_BIT_POS,
  output logic               TRACK_DIRTY,
  input  logic               DIRTY_CLEAR,
  output logic               BUSY,
  output logic [POS_W-1:0]   BITS_WRITTEN
);

  localparam int CNT_MAX = (CLKS_PER_BIT_525 > CLKS_PER_BIT_35) ? CLKS_PER_BIT_525 : CLKS_PER_BIT_35;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] LAST_35  = CNT_W'(CLKS_PER_BIT_35 - 1);
  localparam logic [CNT_W-1:0] LAST_525 = CNT_W'(CLKS_PER_BIT_525 - 1);

  sess_state_t      r_state;
  logic [POS_W-1:0] r_pos;
  logic [CNT_W-1:0] r_cnt;
  logic             r_cell_35;
  logic             r_cell_bit;
  logic [7:0]       r_data;
  logic [7:0]       r_mask;
  logic             r_en_d;
  logic             r_flux_d;
  logic             r_dirty;

  logic               w_en;
  logic [31:0]        w_pos_inc;
  logic               w_wrap;
  logic [POS_W-1:0]   w_pos_nx;
  logic [POS_W-1:0]   w_start_pos;
  logic [CNT_W-1:0]   w_cell_last;
  logic               w_commit;
  logic               w_flux_edge;
  logic               w_bit;
  logic [7:0]         w_bit_sel;
  logic [7:0]         w_data_nx;
  logic [7:0]         w_mask_nx;
  logic               w_flush_commit;
  logic               w_flush_drain;
  logic               w_fl_req;
  logic [7:0]         w_fl_data;
  logic [7:0]         w_fl_mask;
  logic [13:0]        w_byte_idx;
  logic [BRAM_AW-1:0] w_fl_addr;
  logic [BRAM_AW-1:0] w_fe_addr;
  logic [7:0]         w_fe_wdata;
  logic               w_fe_we;
  logic               w_fe_busy;

  assign w_en = WRITE_ACTIVE & MOTOR_SPINNING & TRACK_LOADED & ~WRITE_PROTECT &
                (TRACK_BIT_COUNT != 32'd0);

  // Track position arithmetic; the track length can be any bit count, so
  // wrap is an explicit compare rather than a power-of-two rollover.
  assign w_pos_inc   = {{(32-POS_W){1'b0}}, r_pos} + 32'd1;
  assign w_wrap      = (w_pos_inc == TRACK_BIT_COUNT);
  assign w_pos_nx    = w_wrap ? '0 : w_pos_inc[POS_W-1:0];
  assign w_start_pos = ({{(32-POS_W){1'b0}}, BIT_POSITION} >= TRACK_BIT_COUNT) ? '0 : BIT_POSITION;

  // Cell length is frozen at cell start so a mid-cell drive-type change
  // cannot stretch or truncate the cell in progress.
  assign w_cell_last = r_cell_35 ? LAST_35 : LAST_525;
  assign w_commit    = (r_state == WRITE) & w_en & (r_cnt == w_cell_last);

  // An edge seen in the commit cycle itself still belongs to this cell
  assign w_flux_edge = FLUX_WRITE ^ r_flux_d;
  assign w_bit       = r_cell_bit | w_flux_edge;
  assign w_bit_sel   = 8'h80 >> r_pos[2:0];
  assign w_data_nx   = w_bit ? (r_data | w_bit_sel) : (r_data & ~w_bit_sel);
  assign w_mask_nx   = r_mask | w_bit_sel;

  assign w_flush_commit = w_commit & ((w_pos_nx[2:0] == 3'd0) | w_wrap);
  assign w_flush_drain  = (r_state == WRITE) & ~w_en & (r_mask != 8'h00);
  assign w_fl_req       = w_flush_commit | w_flush_drain;
  assign w_fl_data      = w_flush_drain ? r_data : w_data_nx;
  assign w_fl_mask      = w_flush_drain ? r_mask : w_mask_nx;
  assign w_byte_idx     = r_pos[POS_W-1:3];
  assign w_fl_addr      = BRAM_AW'(w_byte_idx);

  // Session FSM: cell timing, bit accumulation and hand-off of full or
  // trailing partial bytes to the flush engine.
  always_ff @(posedge CLK_14M or posedge RESET) begin
    if (RESET) begin
      r_state    <= IDLE;
      r_pos      <= '0;
      r_cnt      <= '0;
      r_cell_35  <= 1'b0;
      r_cell_bit <= 1'b0;
      r_data     <= '0;
      r_mask     <= '0;
      r_en_d     <= 1'b0;
      r_flux_d   <= 1'b0;
    end else begin
      r_en_d   <= w_en;
      r_flux_d <= FLUX_WRITE;
      case (r_state)
        IDLE: begin
          if (w_en && !r_en_d) begin
            r_state    <= WRITE;
            r_pos      <= w_start_pos;
            r_cnt      <= '0;
            r_cell_35  <= IS_35_INCH;
            r_cell_bit <= 1'b0;
            r_data     <= '0;
            r_mask     <= '0;
          end
        end
        WRITE: begin
          if (!w_en) begin
            // Partial cell is dropped; committed bits leave via the drain flush
            r_state    <= DRAIN;
            r_cnt      <= '0;
            r_cell_bit <= 1'b0;
            r_data     <= '0;
            r_mask     <= '0;
          end else if (w_commit) begin
            r_pos      <= w_pos_nx;
            r_cnt      <= '0;
            r_cell_35  <= IS_35_INCH;
            r_cell_bit <= 1'b0;
            if (w_flush_commit) begin
              r_data <= '0;
              r_mask <= '0;
            end else begin
              r_data <= w_data_nx;
              r_mask <= w_mask_nx;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_flux_edge) begin
              r_cell_bit <= 1'b1;
            end
          end
        end
        DRAIN: begin
          if (!w_fe_busy) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  flux_byte_merge #(
    .AW(BRAM_AW)
  ) u_merge (
    .i_clk   (CLK_14M),
    .i_rst   (RESET),
    .i_req   (w_fl_req),
    .i_addr  (w_fl_addr),
    .i_data  (w_fl_data),
    .i_mask  (w_fl_mask),
    .i_rdata (BRAM_RDATA),
    .o_addr  (w_fe_addr),
    .o_wdata (w_fe_wdata),
    .o_we    (w_fe_we),
    .o_busy  (w_fe_busy)
  );

  // Dirty flag: a write in the same cycle as a clear must not be lost
  always_ff @(posedge CLK_14M or posedge RESET) begin
    if (RESET) begin
      r_dirty <= 1'b0;
    end else if (w_fe_we) begin
      r_dirty <= 1'b1;
    end else if (DIRTY_CLEAR) begin
      r_dirty <= 1'b0;
    end
  end

`ifdef FLUX_WRITE_STATS_EN
  logic [POS_W-1:0] r_bits;

  // Committed-bit counter, saturating, restarted with each dirty clear
  always_ff @(posedge CLK_14M or posedge RESET) begin
    if (RESET) begin
      r_bits <= '0;
    end else if (DIRTY_CLEAR) begin
      r_bits <= w_commit ? POS_W'(1) : '0;
    end else if (w_commit && (r_bits != {POS_W{1'b1}})) begin
      r_bits <= r_bits + POS_W'(1);
    end
  end

  assign BITS_WRITTEN = r_bits;
`else
  assign BITS_WRITTEN = '0;
`endif

  assign BRAM_ADDR   = w_fe_addr;
  assign BRAM_WDATA  = w_fe_wdata;
  assign BRAM_WE     = w_fe_we;
  assign WR_BIT_POS  = r_pos;
  assign TRACK_DIRTY = r_dirty;
  assign BUSY        = (r_state != IDLE) | w_fe_busy;

endmodule

// File: tb/tb_flux_track_writer.sv
// tb/tb_flux_track_writer.sv - scoreboard bench for flux_track_writer with a behavioural track BRAM
`timescale 1ns/1ps
module tb_flux_track_writer;

`ifdef FLUX_WRITE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        CLK_14M = 1'b0;
  logic        RESET;
  logic        IS_35_INCH;
  logic        WRITE_ACTIVE;
  logic        FLUX_WRITE;
  logic        MOTOR_SPINNING;
  logic        TRACK_LOADED;
  logic        WRITE_PROTECT;
  logic [16:0] BIT_POSITION;
  logic [31:0] TRACK_BIT_COUNT;
  logic [13:0] BRAM_ADDR;
  logic [7:0]  BRAM_RDATA;
  logic [7:0]  BRAM_WDATA;
  logic        BRAM_WE;
  logic [16:0] WR_BIT_POS;
  logic        TRACK_DIRTY;
  logic        DIRTY_CLEAR;
  logic        BUSY;
  logic [16:0] BITS_WRITTEN;

  flux_track_writer dut (
    .CLK_14M         (CLK_14M),
    .RESET           (RESET),
    .IS_35_INCH      (IS_35_INCH),
    .WRITE_ACTIVE    (WRITE_ACTIVE),
    .FLUX_WRITE      (FLUX_WRITE),
    .MOTOR_SPINNING  (MOTOR_SPINNING),
    .TRACK_LOADED    (TRACK_LOADED),
    .WRITE_PROTECT   (WRITE_PROTECT),
    .BIT_POSITION    (BIT_POSITION),
    .TRACK_BIT_COUNT (TRACK_BIT_COUNT),
    .BRAM_ADDR       (BRAM_ADDR),
    .BRAM_RDATA      (BRAM_RDATA),
    .BRAM_WDATA      (BRAM_WDATA),
    .BRAM_WE         (BRAM_WE),
    .WR_BIT_POS      (WR_BIT_POS),
    .TRACK_DIRTY     (TRACK_DIRTY),
    .DIRTY_CLEAR     (DIRTY_CLEAR),
    .BUSY            (BUSY),
    .BITS_WRITTEN    (BITS_WRITTEN)
  );

  always #5 CLK_14M = ~CLK_14M;

  int unsigned cyc = 0;
  always @(posedge CLK_14M) cyc <= cyc + 1;

  // Track BRAM: synchronous read, 1-cycle latency; bench preload port
  logic [7:0]  mem [0:16383];
  logic        pre_we   = 1'b0;
  logic [13:0] pre_addr = '0;
  logic [7:0]  pre_data = '0;
  always @(posedge CLK_14M) begin
    BRAM_RDATA <= mem[BRAM_ADDR];
    if (BRAM_WE) mem[BRAM_ADDR] <= BRAM_WDATA;
    else if (pre_we) mem[pre_addr] <= pre_data;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic [13:0] addr;
    logic [7:0]  data;
  } wr_t;

  wr_t         exp_q[$];
  wr_t         e;
  int          n_we   = 0;
  int unsigned we_cyc = 0;
  int unsigned t0     = 0;

  // Scoreboard: every BRAM write is matched against the oldest expectation
  always @(negedge CLK_14M) begin
    if (BRAM_WE) begin
      n_we++;
      we_cyc = cyc;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("we_addr", 32'(BRAM_ADDR), 32'(e.addr));
        chk("we_data", 32'(BRAM_WDATA), 32'(e.data));
      end
    end
  end

  task automatic expect_wr(input logic [13:0] a, input logic [7:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    exp_q.push_back(w);
  endtask

  task automatic preload(input logic [13:0] a, input logic [7:0] d);
    @(negedge CLK_14M);
    pre_addr = a;
    pre_data = d;
    pre_we   = 1'b1;
    @(negedge CLK_14M);
    pre_we   = 1'b0;
  endtask

  task automatic start_session(input logic [16:0] pos, input logic [31:0] tbc);
    @(negedge CLK_14M);
    BIT_POSITION    = pos;
    TRACK_BIT_COUNT = tbc;
    WRITE_ACTIVE    = 1'b1;
    t0              = cyc;
  endtask

  // Cells are given MSB-first: cell i carries pat[n-1-i]; a 1 toggles mid-cell
  task automatic run_cells(input int n, input logic [63:0] pat);
    int cl;
    cl = IS_35_INCH ? 28 : 56;
    for (int i = 0; i < n; i++) begin
      for (int k = 1; k <= cl; k++) begin
        @(negedge CLK_14M);
        if (k == cl / 2 && pat[n-1-i]) FLUX_WRITE = ~FLUX_WRITE;
      end
    end
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    do begin
      @(negedge CLK_14M);
      k++;
    end while (BUSY && k < 300);
    chk(tag, 32'(BUSY), 32'd0);
  endtask

  task automatic end_session(input string tag, input bit use_wp);
    @(negedge CLK_14M);
    if (use_wp) WRITE_PROTECT = 1'b1;
    else WRITE_ACTIVE = 1'b0;
    wait_idle(tag);
    WRITE_ACTIVE  = 1'b0;
    WRITE_PROTECT = 1'b0;
    repeat (2) @(negedge CLK_14M);
  endtask

  task automatic wait_we(input string tag, input int w0, input int lat);
    int k;
    k = 0;
    while (n_we == w0 && k < 20) begin
      @(negedge CLK_14M);
      k++;
    end
    chk(tag, we_cyc - t0, 32'(lat));
  endtask

  task automatic clear_dirty(input string tag);
    @(negedge CLK_14M);
    DIRTY_CLEAR = 1'b1;
    @(negedge CLK_14M);
    DIRTY_CLEAR = 1'b0;
    chk(tag, 32'(TRACK_DIRTY), 32'd0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          w0;
    bit          busy_seen;
    logic [63:0] pat;

    RESET           = 1'b1;
    IS_35_INCH      = 1'b1;
    WRITE_ACTIVE    = 1'b0;
    FLUX_WRITE      = 1'b0;
    MOTOR_SPINNING  = 1'b1;
    TRACK_LOADED    = 1'b1;
    WRITE_PROTECT   = 1'b0;
    BIT_POSITION    = '0;
    TRACK_BIT_COUNT = 32'd50000;
    DIRTY_CLEAR     = 1'b0;
    repeat (3) @(negedge CLK_14M);

    // Reset state
    chk("rst_we",    32'(BRAM_WE), 32'd0);
    chk("rst_addr",  32'(BRAM_ADDR), 32'd0);
    chk("rst_wdata", 32'(BRAM_WDATA), 32'd0);
    chk("rst_pos",   32'(WR_BIT_POS), 32'd0);
    chk("rst_dirty", 32'(TRACK_DIRTY), 32'd0);
    chk("rst_busy",  32'(BUSY), 32'd0);
    chk("rst_bits",  32'(BITS_WRITTEN), 32'd0);
    RESET = 1'b0;
    repeat (2) @(negedge CLK_14M);

    // 3.5": one full byte 10101010 at bit 16 -> byte 2
    preload(14'd2, 8'h00);
    w0 = n_we;
    expect_wr(14'd2, 8'hAA);
    start_session(17'd16, 32'd50000);
    run_cells(8, 64'hAA);
    wait_we("t1_latency", w0, 8 * 28 + 3);
    end_session("t1_idle", 1'b0);
    chk("t1_nwe",   32'(n_we - w0), 32'd1);
    chk("t1_dirty", 32'(TRACK_DIRTY), 32'd1);
    chk("t1_pos",   32'(WR_BIT_POS), 32'd24);
    clear_dirty("t1_dirty_clr");

    // Partial byte 111 at bits 19..21, drained on WRITE_ACTIVE drop
    preload(14'd2, 8'h00);
    w0 = n_we;
    expect_wr(14'd2, 8'h1C);
    start_session(17'd19, 32'd50000);
    run_cells(3, 64'h7);
    end_session("t2a_idle", 1'b0);
    chk("t2a_nwe", 32'(n_we - w0), 32'd1);
    chk("t2a_pos", 32'(WR_BIT_POS), 32'd22);

    // Same partial byte ended by WRITE_PROTECT, bits outside the mask kept
    preload(14'd2, 8'h81);
    w0 = n_we;
    expect_wr(14'd2, 8'h9D);
    start_session(17'd19, 32'd50000);
    run_cells(3, 64'h7);
    end_session("t2b_idle", 1'b1);
    chk("t2b_nwe",   32'(n_we - w0), 32'd1);
    chk("t2b_dirty", 32'(TRACK_DIRTY), 32'd1);
    clear_dirty("t2_dirty_clr");

    // 20-bit track from bit 16: flush at wrap, then tail of byte 0 on drain
    preload(14'd2, 8'h00);
    preload(14'd0, 8'h05);
    w0 = n_we;
    expect_wr(14'd2, 8'hF0);
    expect_wr(14'd0, 8'hF5);
    start_session(17'd16, 32'd20);
    run_cells(8, 64'hFF);
    end_session("t3_idle", 1'b0);
    chk("t3_nwe", 32'(n_we - w0), 32'd2);
    chk("t3_pos", 32'(WR_BIT_POS), 32'd4);
    clear_dirty("t3_dirty_clr");

    // Write-protected disk: 100 cells of flux must change nothing
    w0 = n_we;
    busy_seen = 1'b0;
    @(negedge CLK_14M);
    WRITE_PROTECT = 1'b1;
    WRITE_ACTIVE  = 1'b1;
    for (int k = 0; k < 100 * 28; k++) begin
      @(negedge CLK_14M);
      if (k % 28 == 14) FLUX_WRITE = ~FLUX_WRITE;
      if (BUSY) busy_seen = 1'b1;
    end
    WRITE_ACTIVE  = 1'b0;
    WRITE_PROTECT = 1'b0;
    repeat (2) @(negedge CLK_14M);
    chk("t4_nwe",   32'(n_we - w0), 32'd0);
    chk("t4_dirty", 32'(TRACK_DIRTY), 32'd0);
    chk("t4_busy",  32'(busy_seen), 32'd0);

    // 5.25": 56-cycle cells, full byte 01011010 at bit 8 over 0xFF
    IS_35_INCH = 1'b0;
    preload(14'd1, 8'hFF);
    w0 = n_we;
    expect_wr(14'd1, 8'h5A);
    start_session(17'd8, 32'd50000);
    run_cells(8, 64'h5A);
    wait_we("t5_latency", w0, 8 * 56 + 3);
    end_session("t5_idle", 1'b0);
    chk("t5_nwe", 32'(n_we - w0), 32'd1);
    chk("t5_pos", 32'(WR_BIT_POS), 32'd16);
    IS_35_INCH = 1'b1;

    // Reset during F_WAIT: no write, outputs cleared immediately
    preload(14'd5, 8'h3C);
    w0 = n_we;
    start_session(17'd40, 32'd50000);
    run_cells(8, 64'hFF);
    repeat (2) @(negedge CLK_14M);
    chk("t6_busy_pre", 32'(BUSY), 32'd1);
    RESET = 1'b1;
    #1;
    chk("t6_we",    32'(BRAM_WE), 32'd0);
    chk("t6_addr",  32'(BRAM_ADDR), 32'd0);
    chk("t6_wdata", 32'(BRAM_WDATA), 32'd0);
    chk("t6_pos",   32'(WR_BIT_POS), 32'd0);
    chk("t6_dirty", 32'(TRACK_DIRTY), 32'd0);
    chk("t6_busy",  32'(BUSY), 32'd0);
    chk("t6_bits",  32'(BITS_WRITTEN), 32'd0);
    WRITE_ACTIVE = 1'b0;
    repeat (3) @(negedge CLK_14M);
    RESET = 1'b0;
    repeat (6) @(negedge CLK_14M);
    chk("t6_nwe", 32'(n_we - w0), 32'd0);
    chk("t6_mem", 32'(mem[5]), 32'h3C);

    // 40 random cells = 5 bytes; DIRTY_CLEAR lands on the last BRAM_WE
    for (int b = 0; b < 5; b++) preload(14'(b), 8'h00);
    pat = {$urandom, $urandom};
    w0  = n_we;
    for (int b = 0; b < 5; b++) expect_wr(14'(b), pat[39-8*b -: 8]);
    start_session(17'd0, 32'd50000);
    run_cells(40, pat);
    @(negedge CLK_14M);
    WRITE_ACTIVE = 1'b0;
    chk("t7_bits_40", 32'(BITS_WRITTEN), STATS ? 32'd40 : 32'd0);
    begin
      int k;
      k = 0;
      while (!BRAM_WE && k < 20) begin
        @(negedge CLK_14M);
        k++;
      end
      chk("t7_we_seen", 32'(BRAM_WE), 32'd1);
    end
    DIRTY_CLEAR = 1'b1;
    @(negedge CLK_14M);
    DIRTY_CLEAR = 1'b0;
    chk("t7_dirty", 32'(TRACK_DIRTY), 32'd1);
    chk("t7_bits_0", 32'(BITS_WRITTEN), 32'd0);
    wait_idle("t7_idle");
    chk("t7_nwe", 32'(n_we - w0), 32'd5);

    repeat (4) @(negedge CLK_14M);
    chk("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
